// File: rtl/onehot_scan_decoder_pkg.sv
// Shared constants for the one-hot select decoder: FSM encodings, mode values
// and the scan-limit clamp helper.
package onehot_scan_decoder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Limit a requested final scan index to the last physical output line.
  function automatic int unsigned clamp_last(input int unsigned last,
                                             input int unsigned out_w);
    return (last > out_w - 1) ? out_w - 1 : last;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle between the decoder and its consumer.
interface onehot_scan_decoder_if #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned OUT_W = 16
);
  logic             mode;
  logic             en;
  logic [SEL_W-1:0] sel_in;
  logic             start;
  logic [SEL_W-1:0] last;
  logic             step_ready;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] index;
  logic             valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output mode, en, sel_in, start, last, step_ready,
    input  out, index, valid, busy, done, err
  );

  modport slave (
    input  mode, en, sel_in, start, last, step_ready,
    output out, index, valid, busy, done, err
  );
endinterface

// File: rtl/onehot_scan_decoder_encode.sv
// Combinational index -> one-hot encoder with an in-range flag.
module onehot_encode #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned OUT_W = 16
) (
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] onehot,
  output logic             in_range
);

  // Decode idx; indices past the last line yield all zeros.
  always_comb begin
    onehot   = '0;
    in_range = (32'(idx) < OUT_W);
    for (int unsigned i = 0; i < OUT_W; i++) begin
      onehot[i] = (32'(idx) == i);
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// One-hot select decoder: registered direct decode or ready-paced scan walk.
module onehot_scan_decoder #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned OUT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  onehot_scan_decoder_if.slave bus
);
  import onehot_scan_decoder_pkg::*;

  logic [0:0]       state;
  logic [OUT_W-1:0] out_q;
  logic [SEL_W-1:0] index_q;
  logic [SEL_W-1:0] last_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [SEL_W-1:0] index_inc;
  logic [OUT_W-1:0] dir_onehot;
  logic             dir_ok;
  logic [OUT_W-1:0] scan_onehot;
  logic             scan_ok;

  assign index_inc = index_q + SEL_W'(1);

  onehot_encode #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_dir_enc (
    .idx      (bus.sel_in),
    .onehot   (dir_onehot),
    .in_range (dir_ok)
  );

  // Independent encode of the next scan index, cross-checked against the shift.
  onehot_encode #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_scan_chk (
    .idx      (index_inc),
    .onehot   (scan_onehot),
    .in_range (scan_ok)
  );

  // FSM and output registers; done/err default low so they pulse one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      out_q   <= '0;
      index_q <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (bus.mode == MODE_SCAN) begin
            if (bus.start) begin
              last_q  <= SEL_W'(clamp_last(32'(bus.last), OUT_W));
              index_q <= '0;
              out_q   <= OUT_W'(1);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state   <= ST_SCAN;
            end
          end else if (bus.en) begin
            if (dir_ok) begin
              out_q   <= dir_onehot;
              index_q <= bus.sel_in;
              valid_q <= 1'b1;
            end else begin
              out_q   <= '0;
              index_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (bus.step_ready) begin
            if (index_q == last_q) begin
              out_q   <= '0;
              index_q <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              index_q <= index_inc;
              out_q   <= out_q << 1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_scan_shift: assert property (@(posedge clk) disable iff (rst)
    (state == ST_SCAN && bus.step_ready && index_q != last_q)
      |-> (scan_ok && scan_onehot == (out_q << 1)));

  assign bus.out   = out_q;
  assign bus.index = index_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule
